// File: rtl/ball_pos_snapshot_if.sv
// ball_pos_snapshot_if
//   Bus between the Nios II PIO exports / VGA drawing logic and the
//   ball_pos_snapshot shadow bank.
//   master : drives position words, frame_start and rd_idx; observes read
//            data, stick direction, hw_sig and overrun (testbench / system).
//   slave  : the snapshot block itself.
//   Signals:
//     ball_pos_in  [NUM_BALLS*POS_W] flattened ball words, slot k at k*POS_W
//     poolcue_in   [POS_W]           pool cue position word
//     stick_dir_in [3]               stick direction code
//     frame_start                    one-cycle pulse at start of vertical blank
//     rd_idx       [IDX_W]           read slot (0..NUM_BALLS)
//     rd_pos       [POS_W]           registered front-bank word
//     rd_valid                       registered drawable flag
//     stick_dir    [3]               front-bank stick direction
//     hw_sig                         snapshot-complete toggle
//     overrun                        sticky missed-frame flag
interface ball_pos_snapshot_if #(
  parameter int NUM_BALLS = 16,
  parameter int POS_W     = 20
);
  localparam int IDX_W = $clog2(NUM_BALLS + 1);

  logic [NUM_BALLS*POS_W-1:0] ball_pos_in;
  logic [POS_W-1:0]           poolcue_in;
  logic [2:0]                 stick_dir_in;
  logic                       frame_start;
  logic [IDX_W-1:0]           rd_idx;
  logic [POS_W-1:0]           rd_pos;
  logic                       rd_valid;
  logic [2:0]                 stick_dir;
  logic                       hw_sig;
  logic                       overrun;

  modport master (
    output ball_pos_in, poolcue_in, stick_dir_in, frame_start, rd_idx,
    input  rd_pos, rd_valid, stick_dir, hw_sig, overrun
  );

  modport slave (
    input  ball_pos_in, poolcue_in, stick_dir_in, frame_start, rd_idx,
    output rd_pos, rd_valid, stick_dir, hw_sig, overrun
  );
endinterface

// File: rtl/ball_pos_snapshot.sv
// ball_pos_snapshot
//   Copies the software-written ball / pool cue / stick direction words into
//   a double-buffered shadow bank once per video frame, so the VGA drawing
//   logic always reads a frame-consistent set. Each completed snapshot is
//   reported by toggling hw_sig.
//   Ports:
//     clk_clk        system clock, rising edge
//     reset_reset_n  synchronous active-low reset
//     bus            ball_pos_snapshot_if.slave (see interface header)
//   Optional feature: define BALL_POCKET_MASK_EN to report ball slots whose
//   X field is all ones as not drawable (pocketed). Pool cue slot never masked.
module ball_pos_snapshot #(
  parameter int NUM_BALLS = 16,
  parameter int POS_W     = 20
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  ball_pos_snapshot_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_BALLS + 1);
  localparam int X_W   = 10;

  typedef enum logic [1:0] {IDLE, CAPTURE, SWAP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cap_we, do_swap, last_slot;

  // bank[0] = A, bank[1] = B; front_sel picks the bank being drawn.
  logic [1:0][NUM_BALLS:0][POS_W-1:0] bank;
  logic [1:0][2:0]                    bank_dir;
  logic                               front_sel;

  // Pool cue sits above the balls so slot index maps straight onto a word.
  logic [NUM_BALLS:0][POS_W-1:0] src_words;

  logic             hw_sig_q, overrun_q, rd_valid_q;
  logic [POS_W-1:0] rd_pos_q, front_word;
  logic [IDX_W-1:0] rd_slot;
  logic             rd_in_range, slot_valid;

  assign src_words = {bus.poolcue_in, bus.ball_pos_in};
  assign last_slot = (idx_q == IDX_W'(NUM_BALLS));

  // ---------------- FSM ----------------
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_we  = 1'b0;
    do_swap = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          state_d = CAPTURE;
          idx_d   = '0;
        end
      end
      CAPTURE: begin
        cap_we = 1'b1;
        if (last_slot) begin
          state_d = SWAP;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SWAP: begin
        do_swap = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- read path ----------------
  assign rd_in_range = (bus.rd_idx <= IDX_W'(NUM_BALLS));
  // Keep the bank index in range even when the output is forced to zero.
  assign rd_slot     = rd_in_range ? bus.rd_idx : '0;
  assign front_word  = bank[front_sel][rd_slot];

`ifdef BALL_POCKET_MASK_EN
  assign slot_valid = (rd_slot == IDX_W'(NUM_BALLS)) ||
                      (front_word[POS_W-1 -: X_W] != {X_W{1'b1}});
`else
  assign slot_valid = 1'b1;
`endif

  // ---------------- datapath ----------------
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      bank       <= '0;
      bank_dir   <= '0;
      front_sel  <= 1'b0;
      hw_sig_q   <= 1'b0;
      overrun_q  <= 1'b0;
      rd_pos_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (cap_we) begin
        bank[~front_sel][idx_q] <= src_words[idx_q];
        if (last_slot) bank_dir[~front_sel] <= bus.stick_dir_in;
      end
      if (do_swap) begin
        front_sel <= ~front_sel;
        hw_sig_q  <= ~hw_sig_q;
      end
      // A pulse outside IDLE is dropped; remember that a frame was missed.
      if (bus.frame_start && (state_q != IDLE)) overrun_q <= 1'b1;
      // Uses the pre-swap front_sel on the SWAP edge, so the first read of
      // the new bank is the one registered on the following edge.
      rd_pos_q   <= rd_in_range ? front_word : '0;
      rd_valid_q <= rd_in_range && slot_valid;
    end
  end

  assign bus.rd_pos    = rd_pos_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.stick_dir = bank_dir[front_sel];
  assign bus.hw_sig    = hw_sig_q;
  assign bus.overrun   = overrun_q;
endmodule
